// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-class helper for alu_iter.
// ALU_ITER_DIV_EN selects whether divu is an iterative op or an illegal one.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_ADD_ALT = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_SUB_ALT = 4'd3;
    localparam logic [3:0] OP_AND     = 4'd4;
    localparam logic [3:0] OP_OR      = 4'd5;
    localparam logic [3:0] OP_XOR     = 4'd6;
    localparam logic [3:0] OP_NOR     = 4'd7;
    localparam logic [3:0] OP_SLT     = 4'd8;
    localparam logic [3:0] OP_SLTU    = 4'd9;
    localparam logic [3:0] OP_MULTU   = 4'd10;
    localparam logic [3:0] OP_DIVU    = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide-by-zero is resolved in one cycle by the caller despite divu being iterative here.
    function automatic logic isIterative(input logic [3:0] op);
`ifdef ALU_ITER_DIV_EN
        return (op == OP_MULTU) || (op == OP_DIVU);
`else
        return (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned shift-add multiplier and (with ALU_ITER_DIV_EN) restoring divider.
// One step per cycle for N cycles; o_lo/o_hi present the value after the current step.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
`ifdef ALU_ITER_DIV_EN
    input  logic         i_isDiv,
`endif
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_last,
    output logic [N-1:0] o_lo,
    output logic [N-1:0] o_hi
);

    localparam int CW = $clog2(N);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_b;

    logic [N:0]    w_mulSum;
    logic [N-1:0]  w_mulHi;
    logic [N-1:0]  w_mulLo;

    // Multiplier bits shift out of r_lo while product bits shift in from the top.
    assign w_mulSum           = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {N{1'b0}})};
    assign {w_mulHi, w_mulLo} = {w_mulSum, r_lo[N-1:1]};

`ifdef ALU_ITER_DIV_EN
    logic          r_isDiv;
    logic [N:0]    w_divShift;
    logic [N:0]    w_divDiff;

    // Dividend bits shift from r_lo into the partial remainder; quotient bits fill r_lo.
    assign w_divShift = {r_hi, r_lo[N-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_b};
    assign o_hi = r_isDiv ? (w_divDiff[N] ? w_divShift[N-1:0] : w_divDiff[N-1:0]) : w_mulHi;
    assign o_lo = r_isDiv ? {r_lo[N-2:0], ~w_divDiff[N]} : w_mulLo;
`else
    assign o_hi = w_mulHi;
    assign o_lo = w_mulLo;
`endif

    assign o_last = r_active && (r_cnt == CW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
`ifdef ALU_ITER_DIV_EN
            r_isDiv  <= 1'b0;
`endif
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
`ifdef ALU_ITER_DIV_EN
            r_isDiv  <= i_isDiv;
`endif
        end else if (r_active) begin
            r_hi  <= o_hi;
            r_lo  <= o_lo;
            r_cnt <= r_cnt + CW'(1);
            if (o_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: request/result handshake FSM plus all single-cycle ALU ops.
// Define ALU_ITER_DIV_EN to build the divider; otherwise op 11 reports illegal.
module alu_iter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [3:0]   i_op,
    input  logic [N-1:0] i_in0,
    input  logic [N-1:0] i_in1,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out,
    output logic [N-1:0] o_hi,
    output logic         o_cout,
    output logic         o_ill
);

    state_t       r_state;
    logic [N-1:0] r_out;
    logic [N-1:0] r_hi;
    logic         r_cout;
    logic         r_ill;

    logic         w_accept;
    logic         w_goBusy;
    logic         w_mdLast;
    logic [N-1:0] w_mdLo;
    logic [N-1:0] w_mdHi;
    logic [N:0]   w_add;
    logic [N:0]   w_sub;
    logic [N-1:0] w_out;
    logic [N-1:0] w_hi;
    logic         w_cout;
    logic         w_ill;

    assign w_accept = (r_state == ST_IDLE) && i_in_valid;
    assign w_goBusy = isIterative(i_op) && !((i_op == OP_DIVU) && (i_in1 == '0));

    alu_muldiv_seq #(.N(N)) u_muldiv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_accept && w_goBusy),
`ifdef ALU_ITER_DIV_EN
        .i_isDiv (i_op == OP_DIVU),
`endif
        .i_a     (i_in0),
        .i_b     (i_in1),
        .o_last  (w_mdLast),
        .o_lo    (w_mdLo),
        .o_hi    (w_mdHi)
    );

    // The borrow of the N+1-bit subtraction is exactly the unsigned in0 < in1 flag.
    assign w_add = {1'b0, i_in0} + {1'b0, i_in1};
    assign w_sub = {1'b0, i_in0} - {1'b0, i_in1};

    always_comb begin
        w_out  = '0;
        w_hi   = '0;
        w_cout = 1'b0;
        w_ill  = 1'b0;
        case (i_op)
            OP_ADD, OP_ADD_ALT: begin
                w_out  = w_add[N-1:0];
                w_cout = w_add[N];
            end
            OP_SUB, OP_SUB_ALT: begin
                w_out  = w_sub[N-1:0];
                w_cout = w_sub[N];
            end
            OP_AND:   w_out = i_in0 & i_in1;
            OP_OR:    w_out = i_in0 | i_in1;
            OP_XOR:   w_out = i_in0 ^ i_in1;
            OP_NOR:   w_out = ~(i_in0 | i_in1);
            OP_SLT:   w_out = {{(N-1){1'b0}}, ($signed(i_in0) < $signed(i_in1))};
            OP_SLTU:  w_out = {{(N-1){1'b0}}, (i_in0 < i_in1)};
            OP_MULTU: ;
`ifdef ALU_ITER_DIV_EN
            OP_DIVU: begin
                w_out  = '1;
                w_hi   = i_in0;
                w_cout = 1'b1;
            end
`endif
            default:  w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_hi    <= '0;
            r_cout  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        if (w_goBusy) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_out   <= w_out;
                            r_hi    <= w_hi;
                            r_cout  <= w_cout;
                            r_ill   <= w_ill;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mdLast) begin
                        r_state <= ST_DONE;
                        r_out   <= w_mdLo;
                        r_hi    <= w_mdHi;
                        r_cout  <= 1'b0;
                        r_ill   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_out       = r_out;
    assign o_hi        = r_hi;
    assign o_cout      = r_cout;
    assign o_ill       = r_ill;

endmodule

// File: tb/tb_alu_iter.sv
// Directed scoreboard bench for alu_iter (N = 32); model results queued at accept, popped at out_valid.
// Expectations for op 11 follow ALU_ITER_DIV_EN the same way the design build does.
module tb_alu_iter;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] out;
        logic [N-1:0] hi;
        logic         cout;
        logic         ill;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [3:0]   op;
    logic [N-1:0] in0;
    logic [N-1:0] in1;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] outData;
    logic [N-1:0] hiData;
    logic         cout;
    logic         ill;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_iter #(.N(N)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_op        (op),
        .i_in0       (in0),
        .i_in1       (in1),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out       (outData),
        .o_hi        (hiData),
        .o_cout      (cout),
        .o_ill       (ill)
    );

    function automatic exp_t model(input logic [3:0] mop, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t           e;
        logic [N:0]     wide;
        logic [2*N-1:0] prod;
        e.out  = '0;
        e.hi   = '0;
        e.cout = 1'b0;
        e.ill  = 1'b0;
        e.lat  = 1;
        case (mop)
            4'd0, 4'd1: begin
                wide   = {1'b0, a} + {1'b0, b};
                e.out  = wide[N-1:0];
                e.cout = wide[N];
            end
            4'd2, 4'd3: begin
                e.out  = a - b;
                e.cout = (a < b);
            end
            4'd4: e.out = a & b;
            4'd5: e.out = a | b;
            4'd6: e.out = a ^ b;
            4'd7: e.out = ~(a | b);
            4'd8: e.out = ($signed(a) < $signed(b)) ? {{(N-1){1'b0}}, 1'b1} : {N{1'b0}};
            4'd9: e.out = (a < b) ? {{(N-1){1'b0}}, 1'b1} : {N{1'b0}};
            4'd10: begin
                prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                e.out = prod[N-1:0];
                e.hi  = prod[2*N-1:N];
                e.lat = N + 1;
            end
`ifdef ALU_ITER_DIV_EN
            4'd11: begin
                if (b == '0) begin
                    e.out  = {N{1'b1}};
                    e.hi   = a;
                    e.cout = 1'b1;
                end else begin
                    e.out = a / b;
                    e.hi  = a % b;
                    e.lat = N + 1;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkEq({tag, "_in_ready"},  64'(inReady),  64'(1));
        checkEq({tag, "_out_valid"}, 64'(outValid), 64'(0));
        checkEq({tag, "_out"},       64'(outData),  64'(0));
        checkEq({tag, "_hi"},        64'(hiData),   64'(0));
        checkEq({tag, "_cout"},      64'(cout),     64'(0));
        checkEq({tag, "_ill"},       64'(ill),      64'(0));
    endtask

    task automatic applyStimulus(input logic [3:0] sop, input logic [N-1:0] a, input logic [N-1:0] b);
        checkEq("in_ready_idle", 64'(inReady), 64'(1));
        inValid = 1'b1;
        op      = sop;
        in0     = a;
        in1     = b;
        sbq.push_back(model(sop, a, b));
        @(posedge clk); #1;
        inValid = 1'b0;
        op      = 4'($urandom);
        in0     = $urandom;
        in1     = $urandom;
    endtask

    // Called just after the accepting edge; edges counts that edge as the first.
    task automatic checkOutput(input string tag, input int hold);
        int   edges;
        exp_t e;
        edges = 1;
        while (outValid !== 1'b1 && edges < N + 20) begin
            checkEq({tag, "_busy_in_ready"}, 64'(inReady), 64'(0));
            @(posedge clk); #1;
            edges++;
        end
        e = sbq.pop_front();
        checkEq({tag, "_latency"}, 64'(edges), 64'(e.lat));
        for (int i = 0; i <= hold; i++) begin
            checkEq({tag, "_out_valid"}, 64'(outValid), 64'(1));
            checkEq({tag, "_in_ready"},  64'(inReady),  64'(0));
            checkEq({tag, "_out"},       64'(outData),  64'(e.out));
            checkEq({tag, "_hi"},        64'(hiData),   64'(e.hi));
            checkEq({tag, "_cout"},      64'(cout),     64'(e.cout));
            checkEq({tag, "_ill"},       64'(ill),      64'(e.ill));
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkEq({tag, "_release_valid"}, 64'(outValid), 64'(0));
        checkEq({tag, "_release_ready"}, 64'(inReady),  64'(1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic sawValid;
        exp_t dropped;

        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        op       = '0;
        in0      = '0;
        in1      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleZero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4'd0, 32'h0f00000f, 32'h0234567a);
        checkOutput("add", 0);
        applyStimulus(4'd2, 32'h0f00000f, 32'hf234567a);
        checkOutput("sub_hold", 5);
        applyStimulus(4'd8, 32'h0f00000f, 32'hf234567a);
        checkOutput("slt", 0);
        applyStimulus(4'd9, 32'h0f00000f, 32'hf234567a);
        checkOutput("sltu", 0);
        applyStimulus(4'd8, 32'h80000000, 32'h00000001);
        checkOutput("slt_neg", 0);
        applyStimulus(4'd1, 32'hffffffff, 32'h00000001);
        checkOutput("add_carry", 0);
        applyStimulus(4'd3, 32'h12345678, 32'h12345678);
        checkOutput("sub_equal", 0);
        applyStimulus(4'd4, 32'hf0f0a5a5, 32'h0ff05a5f);
        checkOutput("and", 0);
        applyStimulus(4'd5, 32'hf0f0a5a5, 32'h0ff05a5f);
        checkOutput("or", 0);
        applyStimulus(4'd6, 32'hf0f0a5a5, 32'h0ff05a5f);
        checkOutput("xor", 0);
        applyStimulus(4'd7, 32'hf0f0a5a5, 32'h0ff05a5f);
        checkOutput("nor", 0);
        applyStimulus(4'd10, 32'hffffffff, 32'hffffffff);
        checkOutput("multu_max", 2);
        applyStimulus(4'd10, 32'h12345678, 32'h9abcdef0);
        checkOutput("multu", 0);
        applyStimulus(4'd11, 32'd100, 32'd7);
        checkOutput("divu", 0);
        applyStimulus(4'd11, 32'd5, 32'd0);
        checkOutput("divu_zero", 3);
        applyStimulus(4'd11, 32'hffffffff, 32'd3);
        checkOutput("divu_big", 0);
        applyStimulus(4'd12, 32'h11111111, 32'h22222222);
        checkOutput("illegal12", 0);
        applyStimulus(4'd15, 32'h33333333, 32'h44444444);
        checkOutput("illegal15", 0);
        applyStimulus(4'd0, 32'h00000001, 32'h00000002);
        checkOutput("add_small", 0);

        // Reset ten cycles into a multiply must discard it entirely.
        applyStimulus(4'd10, 32'h12345678, 32'h9abcdef0);
        dropped = sbq.pop_back();
        repeat (9) @(posedge clk);
        #1;
        checkEq("mid_busy_in_ready", 64'(inReady), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        checkIdleZero("mid_reset");
        reset    = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (outValid === 1'b1) sawValid = 1'b1;
        end
        checkEq("no_stale_result", 64'(sawValid), 64'(0));
        checkEq("scoreboard_empty", 64'(sbq.size()), 64'(0));

        applyStimulus(4'd0, 32'hdeadbeef, 32'h01010101);
        checkOutput("add_after_reset", 0);

        $display("[TB] dropped multiply lo was 0x%0h", dropped.out);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
